// File: rtl/grid_game_controller_if.sv
// Move handshake between a player-input source and grid_game_controller.
//   move_valid/move_row/move_col : request from the requester (master)
//   move_ready                   : controller can take a move
//   move_accept/move_reject      : 1-cycle result pulses from the controller
//   reject_cause                 : 0 = out of range, 1 = cell occupied (valid with move_reject)
interface grid_game_controller_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned CW = $clog2(N);

    logic          move_valid;
    logic          move_ready;
    logic [CW-1:0] move_row;
    logic [CW-1:0] move_col;
    logic          move_accept;
    logic          move_reject;
    logic          reject_cause;

    modport master (
        output move_valid, move_row, move_col,
        input  move_ready, move_accept, move_reject, reject_cause
    );

    modport slave (
        input  move_valid, move_row, move_col,
        output move_ready, move_accept, move_reject, reject_cause
    );
endinterface

// File: rtl/grid_game_controller.sv
// Two-player N-in-a-row controller for an N x N board.
// Moves arrive on the mv handshake; after each legal move the row, column, diagonal and
// anti-diagonal through that cell are scanned one cell per cycle, then a decision cycle
// declares a win, a draw, or hands the turn to the other player.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : 1-cycle pulse, clears the board and begins a new game (beats any move)
//   mv             : move handshake (slave side)
//   turn           : player to move (0 = P1, 1 = P2)
//   board          : cell (r,c) at [2*(r*N+c)+:2]; 00 empty, 01 P1, 10 P2
//   move_count     : accepted moves this game
//   game_over      : high once the game has finished
//   winner         : 00 none, 01 P1, 10 P2, 11 draw
module grid_game_controller #(
    parameter int unsigned N            = 3,
    parameter bit          FIRST_PLAYER = 1'b0,
    localparam int unsigned CW          = $clog2(N),
    localparam int unsigned MW          = $clog2(N * N + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    grid_game_controller_if.slave  mv,
    output logic                   turn,
    output logic [2*N*N-1:0]       board,
    output logic [MW-1:0]          move_count,
    output logic                   game_over,
    output logic [1:0]             winner
);
    localparam int unsigned KW = $clog2(N + 1);   // scan index runs 0..N (N = decide)
    localparam int unsigned IW = $clog2(2 * N * N);

    typedef enum logic [1:0] {StIdle, StWaitMove, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [2*N*N-1:0] board_q, board_d;
    logic [MW-1:0]    count_q, count_d;
    logic             turn_q, turn_d;
    logic [CW-1:0]    row_q, row_d, col_q, col_d;
    logic [KW-1:0]    k_q, k_d;
    logic             row_ok_q, row_ok_d, col_ok_q, col_ok_d;
    logic             diag_ok_q, diag_ok_d, anti_ok_q, anti_ok_d;
    logic [1:0]       winner_q, winner_d;
    logic             ready_q, ready_d, accept_q, accept_d, reject_q, reject_d;
    logic             cause_q, cause_d, over_q, over_d;

    logic [1:0]       mark;
    logic             fire, in_range;
    int unsigned      req_r, req_c, kk, r32, c32;
    logic [IW-1:0]    req_base, row_base, col_base, diag_base, anti_base;

    always_comb begin
        mark     = turn_q ? 2'b10 : 2'b01;
        fire     = mv.move_valid & ready_q;
        req_r    = 32'(mv.move_row);
        req_c    = 32'(mv.move_col);
        in_range = (req_r < N) && (req_c < N);
        req_base = in_range ? IW'(2 * (req_r * N + req_c)) : '0;

        // Clamp the scan index so the decide cycle (k == N) never reads past the board.
        kk        = (32'(k_q) < N) ? 32'(k_q) : 32'd0;
        r32       = 32'(row_q);
        c32       = 32'(col_q);
        row_base  = IW'(2 * (r32 * N + kk));
        col_base  = IW'(2 * (kk * N + c32));
        diag_base = IW'(2 * (kk * N + kk));
        anti_base = IW'(2 * (kk * N + (N - 1 - kk)));

        state_d   = state_q;
        board_d   = board_q;
        count_d   = count_q;
        turn_d    = turn_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        row_ok_d  = row_ok_q;
        col_ok_d  = col_ok_q;
        diag_ok_d = diag_ok_q;
        anti_ok_d = anti_ok_q;
        winner_d  = winner_q;
        cause_d   = cause_q;
        accept_d  = 1'b0;
        reject_d  = 1'b0;

        if (start) begin
            state_d  = StWaitMove;
            board_d  = '0;
            count_d  = '0;
            turn_d   = FIRST_PLAYER;
            winner_d = 2'b00;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitMove: begin
                    if (fire) begin
                        if (!in_range) begin
                            reject_d = 1'b1;
                            cause_d  = 1'b0;
                        end else if (board_q[req_base +: 2] != 2'b00) begin
                            reject_d = 1'b1;
                            cause_d  = 1'b1;
                        end else begin
                            board_d[req_base +: 2] = mark;
                            count_d   = count_q + MW'(1);
                            accept_d  = 1'b1;
                            row_d     = mv.move_row;
                            col_d     = mv.move_col;
                            k_d       = '0;
                            row_ok_d  = 1'b1;
                            col_ok_d  = 1'b1;
                            // Diagonals only count when the move lies on them.
                            diag_ok_d = (mv.move_row == mv.move_col);
                            anti_ok_d = (req_r + req_c == N - 1);
                            state_d   = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (32'(k_q) < N) begin
                        row_ok_d  = row_ok_q  & (board_q[row_base  +: 2] == mark);
                        col_ok_d  = col_ok_q  & (board_q[col_base  +: 2] == mark);
                        diag_ok_d = diag_ok_q & (board_q[diag_base +: 2] == mark);
                        anti_ok_d = anti_ok_q & (board_q[anti_base +: 2] == mark);
                        k_d       = k_q + KW'(1);
                    end else if (row_ok_q | col_ok_q | diag_ok_q | anti_ok_q) begin
                        winner_d = mark;
                        state_d  = StDone;
                    end else if (32'(count_q) == N * N) begin
                        winner_d = 2'b11;
                        state_d  = StDone;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StWaitMove;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end

        ready_d = (state_d == StWaitMove);
        over_d  = (state_d == StDone);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            board_q   <= '0;
            count_q   <= '0;
            turn_q    <= FIRST_PLAYER;
            row_q     <= '0;
            col_q     <= '0;
            k_q       <= '0;
            row_ok_q  <= 1'b0;
            col_ok_q  <= 1'b0;
            diag_ok_q <= 1'b0;
            anti_ok_q <= 1'b0;
            winner_q  <= 2'b00;
            ready_q   <= 1'b0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            cause_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            count_q   <= count_d;
            turn_q    <= turn_d;
            row_q     <= row_d;
            col_q     <= col_d;
            k_q       <= k_d;
            row_ok_q  <= row_ok_d;
            col_ok_q  <= col_ok_d;
            diag_ok_q <= diag_ok_d;
            anti_ok_q <= anti_ok_d;
            winner_q  <= winner_d;
            ready_q   <= ready_d;
            accept_q  <= accept_d;
            reject_q  <= reject_d;
            cause_q   <= cause_d;
            over_q    <= over_d;
        end
    end

    assign mv.move_ready   = ready_q;
    assign mv.move_accept  = accept_q;
    assign mv.move_reject  = reject_q;
    assign mv.reject_cause = cause_q;
    assign turn            = turn_q;
    assign board           = board_q;
    assign move_count      = count_q;
    assign game_over       = over_q;
    assign winner          = winner_q;
endmodule
